// File: rtl/exec_sequencer_pkg.sv
// Shared encodings for the exec_sequencer control slice: FSM states, opcodes,
// R-type function codes and ALU operation selects.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LI    = 6'h01;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction-memory fetch handshake: req held until ack, rdata valid with ack.
interface exec_sequencer_if #(parameter int PC_W = 32);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/exec_sequencer_decode.sv
// Combinational instruction decode: opcode/fn to ALU select, writeback source,
// halt and illegal flags.
module seq_decode
  import seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fn,
  output logic [3:0] alu_control,
  output logic       alu_to_reg,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_AND;
    alu_to_reg  = 1'b0;
    is_halt     = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_to_reg = 1'b1;
        case (fn)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_SLL:  alu_control = ALU_SLL;
          FN_SRL:  alu_control = ALU_SRL;
          default: illegal     = 1'b1;
        endcase
      end
      OP_LI:   alu_to_reg = 1'b0;
      OP_HALT: is_halt    = 1'b1;
      default: illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer.
// Optional retired-instruction counter enabled by SEQ_PERF_CNT_EN.
//
// state     | meaning
// IDLE      | after reset, waiting for start
// FETCH     | imem_req high, waiting for ack or timeout
// DECODE    | instr decoded; illegal pulses here
// EXECUTE   | ALU controls valid, no write
// WRITEBACK | RegWrite high, PC += 4
// HALTED    | HALT opcode or fetch timeout; waits for start
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    start,
  exec_sequencer_if.master        imem,
  output logic [31:0]             instr,
  output logic                    RegWrite,
  output logic                    ALUtoReg,
  output logic [3:0]              ALU_Control,
  output logic                    busy,
  output logic                    halted,
  output logic                    illegal,
  output logic                    fault
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             retired_cnt
`endif
);

  localparam int              TO_W    = $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(FETCH_TIMEOUT - 1);

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      dec_alu;
  logic            dec_a2r, dec_halt, dec_illegal;

  seq_decode u_decode (
    .opcode      (instr[31:26]),
    .fn          (instr[5:0]),
    .alu_control (dec_alu),
    .alu_to_reg  (dec_a2r),
    .is_halt     (dec_halt),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    imem.req    = 1'b0;
    RegWrite    = 1'b0;
    ALUtoReg    = 1'b0;
    ALU_Control = ALU_AND;
    busy        = 1'b1;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        busy   = 1'b0;
        halted = (state == ST_HALTED);
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem.req = 1'b1;
        if (imem.ack)         state_next = ST_DECODE;
        else if (to_cnt == '0) state_next = ST_HALTED;
      end
      ST_DECODE: begin
        illegal = dec_illegal;
        if (dec_halt)         state_next = ST_HALTED;
        else if (dec_illegal) state_next = ST_FETCH;
        else                  state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        ALU_Control = dec_alu;
        ALUtoReg    = dec_a2r;
        state_next  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        ALU_Control = dec_alu;
        ALUtoReg    = dec_a2r;
        RegWrite    = 1'b1;
        state_next  = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign imem.addr = pc;

  // Timeout is a down-counter reloaded on every entry into FETCH.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc     <= RESET_PC;
      instr  <= '0;
      fault  <= 1'b0;
      to_cnt <= TO_LOAD;
    end else begin
      if (state_next == ST_FETCH && state != ST_FETCH) to_cnt <= TO_LOAD;
      else if (state == ST_FETCH && to_cnt != '0)      to_cnt <= to_cnt - 1'b1;
      case (state)
        ST_IDLE, ST_HALTED: if (start) begin
          pc    <= RESET_PC;
          fault <= 1'b0;
        end
        ST_FETCH: begin
          if (imem.ack)          instr <= imem.rdata;
          else if (to_cnt == '0) fault <= 1'b1;
        end
        ST_DECODE:    if (dec_illegal) pc <= pc + PC_W'(4);
        ST_WRITEBACK: pc <= pc + PC_W'(4);
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                                retired_cnt <= '0;
    else if ((state == ST_IDLE || state == ST_HALTED) && start) retired_cnt <= '0;
    else if (state == ST_WRITEBACK)                            retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: table of instructions plus hand-written
// halt, timeout, mid-writeback reset and perf counter (SEQ_PERF_CNT_EN) sequences.
module tb_exec_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr;
  logic        RegWrite, ALUtoReg, busy, halted, illegal, fault;
  logic [3:0]  ALU_Control;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  exec_sequencer_if #(.PC_W(32)) imem ();

  exec_sequencer #(.PC_W(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .imem        (imem),
    .instr       (instr),
    .RegWrite    (RegWrite),
    .ALUtoReg    (ALUtoReg),
    .ALU_Control (ALU_Control),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .fault       (fault)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] word;
    int          delay;
    logic [3:0]  alu;
    logic        a2r;
    logic        ill;
    logic        hlt;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] pc_m;
  vec_t        vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 20'h0, fn};
  endfunction

  function automatic vec_t mk(input logic [31:0] w, input int d, input logic [3:0] alu,
                              input logic a2r, input logic ill, input logic hlt);
    vec_t v;
    v.word = w; v.delay = d; v.alu = alu; v.a2r = a2r; v.ill = ill; v.hlt = hlt;
    return v;
  endfunction

  task automatic do_start();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    pc_m = 32'h0;
  endtask

  // Entered at a negedge in FETCH; leaves at a negedge in the following FETCH or HALTED.
  task automatic run_instr(input vec_t v);
    chk("fetch_req", {31'h0, imem.req}, 32'h1);
    chk("fetch_addr", imem.addr, pc_m);
    for (int i = 0; i < v.delay; i++) begin
      imem.ack = 1'b0;
      @(negedge Clk);
      chk("fetch_wait_req", {31'h0, imem.req}, 32'h1);
    end
    imem.ack = 1'b1;
    imem.rdata = v.word;
    @(negedge Clk);
    imem.ack = 1'b0;
    imem.rdata = 32'hDEADBEEF;
    chk("dec_instr", instr, v.word);
    chk("dec_illegal", {31'h0, illegal}, {31'h0, v.ill});
    chk("dec_regwrite", {31'h0, RegWrite}, 32'h0);
    chk("dec_busy", {31'h0, busy}, 32'h1);
    @(negedge Clk);
    if (v.hlt) begin
      chk("halt_halted", {31'h0, halted}, 32'h1);
      chk("halt_busy", {31'h0, busy}, 32'h0);
      chk("halt_regwrite", {31'h0, RegWrite}, 32'h0);
      chk("halt_pc", imem.addr, pc_m);
    end else if (v.ill) begin
      pc_m = pc_m + 32'd4;
      chk("ill_pulse_end", {31'h0, illegal}, 32'h0);
      chk("ill_regwrite", {31'h0, RegWrite}, 32'h0);
      chk("ill_req", {31'h0, imem.req}, 32'h1);
      chk("ill_next_pc", imem.addr, pc_m);
    end else begin
      imem.ack = 1'b1;
      imem.rdata = 32'h12345678;
      chk("ex_regwrite", {31'h0, RegWrite}, 32'h0);
      chk("ex_alu", {28'h0, ALU_Control}, {28'h0, v.alu});
      chk("ex_a2r", {31'h0, ALUtoReg}, {31'h0, v.a2r});
      @(negedge Clk);
      imem.ack = 1'b0;
      chk("wb_regwrite", {31'h0, RegWrite}, 32'h1);
      chk("wb_alu", {28'h0, ALU_Control}, {28'h0, v.alu});
      chk("wb_a2r", {31'h0, ALUtoReg}, {31'h0, v.a2r});
      chk("wb_instr_held", instr, v.word);
      @(negedge Clk);
      pc_m = pc_m + 32'd4;
      chk("post_regwrite", {31'h0, RegWrite}, 32'h0);
      chk("post_alu", {28'h0, ALU_Control}, 32'h0);
      chk("post_a2r", {31'h0, ALUtoReg}, 32'h0);
      chk("post_pc", imem.addr, pc_m);
    end
  endtask

  initial begin
    vec_t add_v, li_v, halt_v;
    add_v  = mk(rtype(6'h20), 0, 4'd2, 1'b1, 1'b0, 1'b0);
    li_v   = mk({6'h01, 5'h00, 21'h1FFFFF}, 2, 4'd0, 1'b0, 1'b0, 1'b0);
    halt_v = mk({6'h3F, 26'h0}, 1, 4'd0, 1'b0, 1'b0, 1'b1);
    vecs[0]  = mk(rtype(6'h22), 0, 4'd6, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(rtype(6'h24), 1, 4'd0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(rtype(6'h25), 0, 4'd1, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(rtype(6'h2A), 3, 4'd7, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(rtype(6'h00), 0, 4'd3, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(rtype(6'h02), 0, 4'd4, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk({6'h05, 26'h0}, 0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(rtype(6'h3B), 2, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(rtype(6'h20), 15, 4'd2, 1'b1, 1'b0, 1'b0);
    vecs[9]  = li_v;
    vecs[10] = halt_v;

    imem.ack = 1'b0;
    imem.rdata = 32'h0;
    #12;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_req", {31'h0, imem.req}, 32'h0);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_regwrite", {31'h0, RegWrite}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // ADD, LI, HALT at 0/4/8, then restart from RESET_PC
    do_start();
    run_instr(add_v);
    run_instr(li_v);
    run_instr(halt_v);
    do_start();
    chk("restart_addr", imem.addr, 32'h0);

    for (int i = 0; i < 11; i++) run_instr(vecs[i]);

    // Fetch timeout; a start pulse mid-fetch must not restart the counter
    do_start();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", {31'h0, imem.req}, 32'h1);
      start = (i == 5);
      @(negedge Clk);
      start = 1'b0;
    end
    chk("to_fault", {31'h0, fault}, 32'h1);
    chk("to_halted", {31'h0, halted}, 32'h1);
    chk("to_req_drop", {31'h0, imem.req}, 32'h0);
    do_start();
    chk("to_fault_clr", {31'h0, fault}, 32'h0);
    chk("to_refetch", imem.addr, 32'h0);

    // Reset asserted during WRITEBACK of the instruction at PC 4
    run_instr(add_v);
    imem.ack = 1'b1;
    imem.rdata = add_v.word;
    @(negedge Clk);
    imem.ack = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_wb_regwrite", {31'h0, RegWrite}, 32'h1);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_regwrite", {31'h0, RegWrite}, 32'h0);
    chk("mid_rst_pc", imem.addr, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    do_start();
    for (int i = 0; i < 3; i++) run_instr(add_v);
`ifdef SEQ_PERF_CNT_EN
    chk("perf_cnt3", retired_cnt, 32'd3);
`endif
    #2 Reset = 1'b0;
    #1;
`ifdef SEQ_PERF_CNT_EN
    chk("perf_cnt_rst", retired_cnt, 32'd0);
`endif
    chk("final_rst_req", {31'h0, imem.req}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
